// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two cache requesters, the memory-port arbiter and the backing memory.
// The arbiter connects through "master" (it masters the memory port); the environment uses "slave".
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 128
);
    // Handshake: rN_req is a one-cycle pulse taken only when rN_busy=0 (or on the
    // completing edge); a refused pulse yields rN_overflow. mem_req is held with
    // stable mem_* until mem_ack is sampled high on clk or the wait times out.
    logic              r0_req;
    logic              r0_write;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_busy;
    logic              r0_done;
    logic              r0_err;
    logic              r0_overflow;
    logic [LINE_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_write;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_busy;
    logic              r1_done;
    logic              r1_err;
    logic              r1_overflow;
    logic [LINE_W-1:0] r1_rdata;

    logic              mem_req;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_read_data;

    logic              grant_id;
    logic [31:0]       grant_count0;
    logic [31:0]       grant_count1;
    logic [15:0]       timeout_count;
    logic [1:0]        state_dbg;

    modport master (
        input  r0_req, r0_write, r0_addr, r0_wdata,
        input  r1_req, r1_write, r1_addr, r1_wdata,
        output r0_busy, r0_done, r0_err, r0_overflow, r0_rdata,
        output r1_busy, r1_done, r1_err, r1_overflow, r1_rdata,
        output mem_req, mem_write, mem_addr, mem_write_data,
        input  mem_ack, mem_read_data,
        output grant_id, grant_count0, grant_count1, timeout_count, state_dbg
    );

    modport slave (
        output r0_req, r0_write, r0_addr, r0_wdata,
        output r1_req, r1_write, r1_addr, r1_wdata,
        input  r0_busy, r0_done, r0_err, r0_overflow, r0_rdata,
        input  r1_busy, r1_done, r1_err, r1_overflow, r1_rdata,
        input  mem_req, mem_write, mem_addr, mem_write_data,
        output mem_ack, mem_read_data,
        input  grant_id, grant_count0, grant_count1, timeout_count, state_dbg
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between two cache requesters,
// with per-port pending slots, a mem_req/mem_ack handshake with timeout, and counters.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.master   bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        req_in;
    logic              wr_in    [2];
    logic [ADDR_W-1:0] addr_in  [2];
    logic [DATA_W-1:0] wdata_in [2];

    logic [1:0]        slot_v;
    logic              slot_w   [2];
    logic [ADDR_W-1:0] slot_a   [2];
    logic [DATA_W-1:0] slot_d   [2];

    logic              last_q;
    logic              gid_q;
    logic              err_q;
    logic [CNT_W-1:0]  wait_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [LINE_W-1:0] rdata_q  [2];
    logic [1:0]        ovf_q;
    logic [31:0]       gcount_q [2];
    logic [15:0]       tcount_q;

    logic              grant_go;
    logic              grant_port;
    logic              ack_go;
    logic              abort_go;
    logic [1:0]        completing;
    logic [1:0]        accept;

    assign req_in      = {bus.r1_req, bus.r0_req};
    assign wr_in[0]    = bus.r0_write;
    assign wr_in[1]    = bus.r1_write;
    assign addr_in[0]  = bus.r0_addr;
    assign addr_in[1]  = bus.r1_addr;
    assign wdata_in[0] = bus.r0_wdata;
    assign wdata_in[1] = bus.r1_wdata;

    // A slot frees on the RESP edge, so a pulse landing on that same edge refills it.
    assign completing[0] = (state_q == S_RESP) && !gid_q;
    assign completing[1] = (state_q == S_RESP) &&  gid_q;
    assign accept        = req_in & (~slot_v | completing);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_go   = 1'b0;
        grant_port = 1'b0;
        ack_go     = 1'b0;
        abort_go   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (slot_v != 2'b00) begin
                    grant_go   = 1'b1;
                    grant_port = (slot_v == 2'b11) ? ~last_q : slot_v[1];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.mem_ack) begin
                    ack_go  = 1'b1;
                    state_d = S_RESP;
                end else if (wait_q == WAIT_LAST) begin
                    abort_go = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_v      <= 2'b00;
            ovf_q       <= 2'b00;
            last_q      <= 1'b1;
            gid_q       <= 1'b0;
            err_q       <= 1'b0;
            wait_q      <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tcount_q    <= '0;
            for (int n = 0; n < 2; n++) begin
                slot_w[n]   <= 1'b0;
                slot_a[n]   <= '0;
                slot_d[n]   <= '0;
                rdata_q[n]  <= '0;
                gcount_q[n] <= '0;
            end
        end else begin
            if (grant_go) begin
                gid_q       <= grant_port;
                mem_write_q <= slot_w[grant_port];
                mem_addr_q  <= slot_a[grant_port];
                mem_wdata_q <= slot_d[grant_port];
                err_q       <= 1'b0;
                wait_q      <= '0;
            end else if (state_q == S_ISSUE) begin
                wait_q <= wait_q + 1'b1;
            end

            if (ack_go && !mem_write_q) begin
                rdata_q[gid_q] <= bus.mem_read_data;
            end
            if (abort_go) begin
                err_q          <= 1'b1;
                rdata_q[gid_q] <= '0;
            end

            if (state_q == S_RESP) begin
                last_q <= gid_q;
                if (err_q) begin
                    if (tcount_q != 16'hFFFF) begin
                        tcount_q <= tcount_q + 16'd1;
                    end
                end else begin
                    gcount_q[gid_q] <= gcount_q[gid_q] + 32'd1;
                end
            end

            ovf_q <= req_in & ~accept;
            for (int n = 0; n < 2; n++) begin
                if (accept[n]) begin
                    slot_v[n] <= 1'b1;
                    slot_w[n] <= wr_in[n];
                    slot_a[n] <= addr_in[n];
                    slot_d[n] <= wdata_in[n];
                end else if (completing[n]) begin
                    slot_v[n] <= 1'b0;
                end
            end
        end
    end

    assign bus.mem_req        = (state_q == S_ISSUE);
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;

    assign bus.r0_busy     = slot_v[0];
    assign bus.r1_busy     = slot_v[1];
    assign bus.r0_done     = completing[0];
    assign bus.r1_done     = completing[1];
    assign bus.r0_err      = completing[0] & err_q;
    assign bus.r1_err      = completing[1] & err_q;
    assign bus.r0_overflow = ovf_q[0];
    assign bus.r1_overflow = ovf_q[1];
    assign bus.r0_rdata    = rdata_q[0];
    assign bus.r1_rdata    = rdata_q[1];

    assign bus.grant_id      = gid_q;
    assign bus.grant_count0  = gcount_q[0];
    assign bus.grant_count1  = gcount_q[1];
    assign bus.timeout_count = tcount_q;
    assign bus.state_dbg     = state_q;
endmodule
